// File: rtl/clk_divider_pkg.sv
// clk_divider_pkg: shared defaults and counter-width helper for the clock divider
package clk_divider_pkg;
  localparam int DEFAULT_N = 4;
  // Clamp to one bit so an illegal N still elaborates far enough to report its error
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/clk_divider.sv
// clk_divider: integer divide-by-N of clk_in into a registered square wave plus a wrap tick
//   clk_in  in   system clock, rising edge
//   rst     in   asynchronous active-low reset
//   clk_out out  divided clock, low floor(N/2) then high ceil(N/2) cycles, registered
//   tick    out  one clk_in cycle pulse each time the counter wraps to 0
module clk_divider
  import clk_divider_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic clk_in,
  input  logic rst,
  output logic clk_out,
  output logic tick
);
  localparam int CNT_W = cnt_width(N);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(N / 2);
  if (N < 2) begin : g_bad_n
    $error("clk_divider: N must be >= 2");
  end
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic clk_out_q, tick_q;
  // Outputs are decoded from the next count so they change on the same edge as the counter
  always_comb cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
  always_ff @(posedge clk_in or negedge rst)
    if (!rst) begin
      cnt_q     <= '0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      clk_out_q <= cnt_d >= HALF;
      tick_q    <= cnt_d == '0;
    end
  assign clk_out = clk_out_q;
  assign tick    = tick_q;
endmodule

// File: tb/tb_clk_divider.sv
// tb_clk_divider: random reset/run bench for clk_divider at N = 4, 5 and 2
module tb_clk_divider;
  logic clk_in = 1'b0;
  logic rst = 1'b0;
  logic [2:0] co, tk;
  int checks = 0, errors = 0;
  int k = 0;
  int rises4 = 0;
  int ticks[3] = '{0, 0, 0};
  int nv[3] = '{4, 5, 2};
  always #5 clk_in = ~clk_in;
  clk_divider #(.N(4)) u_n4 (.clk_in(clk_in), .rst(rst), .clk_out(co[0]), .tick(tk[0]));
  clk_divider #(.N(5)) u_n5 (.clk_in(clk_in), .rst(rst), .clk_out(co[1]), .tick(tk[1]));
  clk_divider #(.N(2)) u_n2 (.clk_in(clk_in), .rst(rst), .clk_out(co[2]), .tick(tk[2]));
  always @(posedge co[0]) rises4++;
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic check_zero(input string tag);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s clk_out N=%0d", tag, nv[i]), int'(co[i]), 0);
      check($sformatf("%s tick N=%0d", tag, nv[i]), int'(tk[i]), 0);
    end
  endtask
  // After k rising edges since release the count is k mod N; outputs follow from it
  task automatic run(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk_in);
      k++;
      for (int i = 0; i < 3; i++) begin
        check($sformatf("clk_out N=%0d k=%0d", nv[i], k), int'(co[i]), int'((k % nv[i]) >= nv[i] / 2));
        check($sformatf("tick N=%0d k=%0d", nv[i], k), int'(tk[i]), int'((k % nv[i]) == 0));
        if (tk[i]) ticks[i]++;
      end
    end
  endtask
  task automatic async_reset(input int delay);
    #(delay);
    rst = 1'b0;
    #1;
    check_zero("async reset");
    repeat ($urandom_range(1, 3)) begin
      @(negedge clk_in);
      check_zero("held reset");
    end
    rst = 1'b1;
    k = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (10) @(negedge clk_in);
    check_zero("reset");
    rst = 1'b1;
    rises4 = 0;
    run(1000);
    check("rises N=4 10us", rises4, 250);
    check("ticks N=4 10us", ticks[0], 250);
    check("ticks N=5 10us", ticks[1], 200);
    check("ticks N=2 10us", ticks[2], 500);
    run(3);
    check("mid-high clk_out N=4", int'(co[0]), 1);
    @(posedge clk_in);
    async_reset(2);
    run(12);
    for (int r = 0; r < 25; r++) begin
      run($urandom_range(1, 15));
      if ($urandom_range(0, 1) == 1) @(posedge clk_in);
      async_reset($urandom_range(1, 3));
    end
    run(20);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
